idex_execute: RTL
=================

Name: idex_execute

Overview:
Execute stage of the 4-stage 8-bit pipeline. Holds the ID/EX pipeline register, resolves operands through a forwarding path from the EX/WB register, and runs the 8-bit ALU. Its combinational outputs drive the EX/WB register inputs (result, regwrite, destination). Also keeps a registered Z/C flag pair.

Parameters:
DW, 8, datapath width (fixed at 8 for this core; ALU encodings assume it)
AW, 3, register address width (8 architectural registers, all writable)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high; clears stage register and flags
id_valid  in  1  decode presents a valid instruction
id_alu_op  in  3  ALU operation
id_rs1_addr  in  3  source 1 register address
id_rs2_addr  in  3  source 2 register address
id_rs1_data  in  8  source 1 value read in decode
id_rs2_data  in  8  source 2 value read in decode
id_imm  in  8  immediate
id_use_imm  in  1  operand B = immediate instead of rs2
id_regwrite  in  1  instruction writes a register
id_dst  in  3  destination register
hold  in  1  freeze stage contents, issue bubble downstream
flush  in  1  load bubble into stage
fwd_result  in  8  EX/WB registered ALU result
fwd_regwrite  in  1  EX/WB registered regwrite
fwd_dst  in  3  EX/WB registered destination
alu_result_out  out  8  ALU result (combinational from stage regs), feeds EX/WB
regwrite_out  out  1  ex_valid & ex_regwrite & !hold
dst_out  out  3  stage destination
flag_z  out  1  registered zero flag
flag_c  out  1  registered carry/borrow flag

Behaviour:
- Reset (async, high): ex_valid, ex_regwrite, ex_op, ex_dst, ex_use_imm, all addresses/data/imm = 0; flag_z = flag_c = 0. Outputs after reset: alu_result_out = 0 (ADD 0+0), regwrite_out = 0, dst_out = 0.
- Stage register update on posedge clk, priority: flush > hold > load. Flush: ex_valid = 0, ex_regwrite = 0, other fields don't-care (cleared to 0). Hold: all fields keep value. Otherwise capture all id_* fields.
- Forwarding (combinational): opA = (fwd_regwrite && fwd_dst == ex_rs1_addr) ? fwd_result : ex_rs1_data. opB = ex_use_imm ? ex_imm : (fwd_regwrite && fwd_dst == ex_rs2_addr) ? fwd_result : ex_rs2_data. Register 0 not special.
- ALU ops (result 8-bit, carry C):
  000 ADD: {C,R} = A+B (9-bit)
  001 SUB: R = A-B mod 256; C = 1 when A < B (borrow)
  010 AND, 011 OR, 100 XOR: C = 0
  101 SHL: R = A<<1, C = A[7]
  110 SHR (logical): R = A>>1, C = A[0]
  111 PASS: R = B, C = 0
- Z = (R == 0).
- Latency: operands captured at edge N; result valid combinationally after edge N; EX/WB captures it at edge N+1.
- Flags: at posedge, if ex_valid && !hold && !reset, flag_z/flag_c <= Z/C of current instruction; otherwise unchanged. Flags update regardless of ex_regwrite.
- hold=1: regwrite_out forced 0 so EX/WB never captures a held instruction twice; the instruction retires on the first cycle hold=0.
- flush and hold same cycle: flush wins; bubble loaded.
- Reset mid-operation: in-flight instruction discarded, no flag update.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> regwrite_out = 0, flag_z = 0, flag_c = 0 immediately, without a clock edge.
- ADD carry: rs1=0xF0, rs2=0x20, op=000, dst=5, regwrite=1 -> alu_result_out = 0x10, regwrite_out = 1, dst_out = 5; next edge flag_c = 1, flag_z = 0.
- SUB borrow/zero: 0x05-0x07 -> 0xFE, C=1; then 0x33-0x33 -> 0x00, Z=1, C=0.
- Forwarding: ex_rs1_addr = ex_rs2_addr = 3, fwd_regwrite = 1, fwd_dst = 3, fwd_result = 0x40, rs1/rs2 data 0x01, op=ADD -> 0x80; with use_imm=1, imm=0x02 -> 0x42; with fwd_regwrite = 0 -> 0x02 (ADD data 0x01+0x01).
- Hold: load SHL of 0x81, hold=1 for 2 cycles -> alu_result_out = 0x02 throughout, regwrite_out = 0, flags unchanged; hold released -> regwrite_out = 1 for exactly one cycle, flag_c = 1 after that edge.
- Flush priority: flush = hold = 1 with valid instruction in stage -> next cycle regwrite_out = 0, ex_valid = 0, flags unchanged.

Source files
------------

// File: rtl/idex_execute.sv
// ID/EX pipeline register, EX/WB forwarding and 8-bit ALU.
// Also holds the registered zero/carry flag pair.
package idex_pkg;

  localparam int DW_P = 8;
  localparam int AW_P = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    alu_op_e           alu_op;
    logic [AW_P-1:0]   dst;
    logic              use_imm;
    logic [AW_P-1:0]   rs1_addr;
    logic [AW_P-1:0]   rs2_addr;
    logic [DW_P-1:0]   rs1_data;
    logic [DW_P-1:0]   rs2_data;
    logic [DW_P-1:0]   imm;
  } id_ex_t;

endpackage

module idex_execute
  import idex_pkg::*;
#(
  parameter int DW = DW_P,
  parameter int AW = AW_P
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [2:0]    id_alu_op,
  input  logic [AW-1:0] id_rs1_addr,
  input  logic [AW-1:0] id_rs2_addr,
  input  logic [DW-1:0] id_rs1_data,
  input  logic [DW-1:0] id_rs2_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic          id_regwrite,
  input  logic [AW-1:0] id_dst,
  input  logic          hold,
  input  logic          flush,
  input  logic [DW-1:0] fwd_result,
  input  logic          fwd_regwrite,
  input  logic [AW-1:0] fwd_dst,
  output logic [DW-1:0] alu_result_out,
  output logic          regwrite_out,
  output logic [AW-1:0] dst_out,
  output logic          flag_z,
  output logic          flag_c
);

  id_ex_t ex_q, ex_d;

  logic flag_z_q, flag_z_d;
  logic flag_c_q, flag_c_d;

  logic          fwd_a_hit;
  logic          fwd_b_hit;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] res;
  logic          carry;
  logic          zero;

  // Stage register: flush beats hold beats load.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!hold) begin
      ex_d.valid    = id_valid;
      ex_d.regwrite = id_regwrite;
      ex_d.alu_op   = alu_op_e'(id_alu_op);
      ex_d.dst      = id_dst;
      ex_d.use_imm  = id_use_imm;
      ex_d.rs1_addr = id_rs1_addr;
      ex_d.rs2_addr = id_rs2_addr;
      ex_d.rs1_data = id_rs1_data;
      ex_d.rs2_data = id_rs2_data;
      ex_d.imm      = id_imm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign fwd_a_hit = fwd_regwrite
                   && (fwd_dst == ex_q.rs1_addr);
  assign fwd_b_hit = fwd_regwrite
                   && (fwd_dst == ex_q.rs2_addr);

  always_comb begin
    op_a = fwd_a_hit ? fwd_result : ex_q.rs1_data;
    op_b = ex_q.rs2_data;
    if (ex_q.use_imm) begin
      op_b = ex_q.imm;
    end else if (fwd_b_hit) begin
      op_b = fwd_result;
    end
  end

  // Bit DW of the widened difference is the borrow.
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    unique case (ex_q.alu_op)
      OP_ADD: begin
        res   = sum[DW-1:0];
        carry = sum[DW];
      end
      OP_SUB: begin
        res   = diff[DW-1:0];
        carry = diff[DW];
      end
      OP_AND: res = op_a & op_b;
      OP_OR:  res = op_a | op_b;
      OP_XOR: res = op_a ^ op_b;
      OP_SHL: begin
        res   = {op_a[DW-2:0], 1'b0};
        carry = op_a[DW-1];
      end
      OP_SHR: begin
        res   = {1'b0, op_a[DW-1:1]};
        carry = op_a[0];
      end
      OP_PASS: res = op_b;
      default: begin
        res   = '0;
        carry = 1'b0;
      end
    endcase
  end

  assign zero = (res == '0);

  // Flags retire with the instruction, so a held op leaves them alone.
  always_comb begin
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (ex_q.valid && !hold) begin
      flag_z_d = zero;
      flag_c_d = carry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign alu_result_out = res;
  assign regwrite_out   = ex_q.valid
                        & ex_q.regwrite
                        & ~hold;
  assign dst_out        = ex_q.dst;
  assign flag_z         = flag_z_q;
  assign flag_c         = flag_c_q;

endmodule
